// File: rtl/recovery.sv
// Lockstep recovery controller: shadows the agreed register writes and, on a
// comparator mismatch, halts both cores and replays the shadow file into them.
//
// state  | meaning
// IDLE   | shadowing agreed writes, watching error_i
// HALT   | one-cycle pipeline drain, replay counter loaded with 1
// REPLAY | restore write of shadow[counter] to both register files
// DONE   | one-cycle done_o pulse before returning to IDLE
module recovery #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  chk_we_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_i,
  input  logic [DATA_WIDTH-1:0] chk_data_i,
  input  logic                  error_i,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  done_o,
  output logic [7:0]            error_count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HALT   = 2'd1,
    REPLAY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   shadow [DEPTH];
  logic [7:0]              err_cnt;
  logic                    shadow_we;
  logic                    err_start;

  // Writes that coincide with a mismatch are suspect and never reach the shadow.
  assign shadow_we = (state == IDLE) && chk_we_i && !error_i && (chk_addr_i != '0);
  assign err_start = (state == IDLE) && error_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (error_i) state_nxt = HALT;
      end
      HALT: begin
        cnt_nxt   = ADDR_WIDTH'(1);
        state_nxt = REPLAY;
      end
      REPLAY: begin
        if (cnt == {ADDR_WIDTH{1'b1}}) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (shadow_we) begin
      shadow[chk_addr_i] <= chk_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (err_start && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Outputs depend only on registered state, counter and shadow contents.
  always_comb begin
    halt_o    = 1'b0;
    rf_we_o   = 1'b0;
    rf_addr_o = '0;
    rf_data_o = '0;
    done_o    = 1'b0;
    case (state)
      IDLE: ;
      HALT: halt_o = 1'b1;
      REPLAY: begin
        halt_o    = 1'b1;
        rf_we_o   = 1'b1;
        rf_addr_o = cnt;
        rf_data_o = (cnt == '0) ? '0 : shadow[cnt];
      end
      DONE: begin
        halt_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign error_count_o = err_cnt;

endmodule
